mem_access_arbiter: RTL

//   Two-port round-robin arbiter and sequencer for the single-port 8-bit Memory_Unit.

---
 rtl/mem_access_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/mem_access_arbiter.sv
// Two-port round-robin arbiter/sequencer driving a single-port memory (combinational read, synchronous write).
// Latency: request sampled in IDLE, memory pins driven the next cycle, ack one cycle after that (3-cycle access).
// Backpressure: a request is held until its ack; a losing request stays pending until the next IDLE.
// Optional build macro MEM_ARB_STATS_EN adds the saturating conflict_cnt output.
module mem_access_arbiter #(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [ADDR_SIZE-1:0] addr0,
    input  logic [ADDR_SIZE-1:0] addr1,
    input  logic [WORD_SIZE-1:0] wdata0,
    input  logic [WORD_SIZE-1:0] wdata1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [WORD_SIZE-1:0] rdata,
    output logic [ADDR_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0] mem_data_in,
    output logic                 mem_write,
    input  logic [WORD_SIZE-1:0] mem_data_out
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [7:0]           conflict_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   gnt_port;
    logic   pick;

    // Round-robin choice: a lone request wins outright, a tie goes to the port not served last.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last_grant;
        end else begin
            pick = req1;
        end
    end

    // Sequencer: IDLE grants and loads the memory pins, ACCESS captures read data, ACK pulses completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            gnt_port     <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            rdata        <= '0;
            mem_address  <= '0;
            mem_data_in  <= '0;
            mem_write    <= 1'b0;
`ifdef MEM_ARB_STATS_EN
            conflict_cnt <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef MEM_ARB_STATS_EN
                    if (req0 && req1 && (conflict_cnt != 8'hFF)) begin
                        conflict_cnt <= conflict_cnt + 8'd1;
                    end
`endif
                    if (req0 || req1) begin
                        gnt_port    <= pick;
                        last_grant  <= pick;
                        mem_address <= pick ? addr1 : addr0;
                        mem_data_in <= pick ? wdata1 : wdata0;
                        mem_write   <= pick ? we1 : we0;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    // mem_write still reflects the granted direction during this cycle.
                    if (!mem_write) begin
                        rdata <= mem_data_out;
                    end
                    mem_write <= 1'b0;
                    ack0      <= ~gnt_port;
                    ack1      <= gnt_port;
                    state     <= ACK;
                end
                ACK: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ack0      <= 1'b0;
                    ack1      <= 1'b0;
                    mem_write <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
